mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS pipeline memory stage. Consumes the EX-stage outputs ALUOutM, WriteDataM and WriteRegM, plus the M-stage control bits.
- Performs loads and stores over a variable-latency req/ack data-memory port.
- Registers the writeback-stage bundle and produces ResultW, which feeds back to EX forwarding.
- Drives StallM to freeze upstream pipeline registers while a memory access is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ValidM  in  1  M-stage slot holds a real instruction.
- ALUOutM  in  DATA_W  ALU result from EX; serves as the memory address for loads and stores.
- WriteDataM  in  DATA_W  store data from EX.
- WriteRegM  in  REG_W  destination register.
- RegWriteM  in  1  instruction writes the register file.
- MemtoRegM  in  1  load.
- MemWriteM  in  1  store.
- DmemReq  out  1  memory request.
- DmemWe  out  1  request is a write.
- DmemAddr  out  DATA_W  request address.
- DmemWData  out  DATA_W  store data.
- DmemAck  in  1  access complete; DmemRData valid in the same cycle.
- DmemRData  in  DATA_W  load data.
- StallM  out  1  freeze IF/ID/EX/M pipeline registers this cycle.
- ALUOutW  out  DATA_W  registered ALU result.
- ReadDataW  out  DATA_W  registered load data.
- WriteRegW  out  REG_W  registered destination register.
- RegWriteW  out  1  registered write enable.
- MemtoRegW  out  1  registered load flag.
- ResultW  out  DATA_W  MemtoRegW ? ReadDataW : ALUOutW (combinational).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all W outputs 0, DmemReq 0, state IDLE. Reset mid-access abandons the request. DmemReq drops immediately. A late DmemAck is ignored.
- Memop: MemOp = ValidM & (MemtoRegM | MemWriteM). MemtoRegM and MemWriteM both high is treated as a store; MemtoRegW is forced to 0.
- FSM state IDLE:
  - If MemOp: DmemReq=1 combinationally. DmemAddr=ALUOutM, DmemWData=WriteDataM, DmemWe=MemWriteM. Capture addr/data/we/dest/control into holding registers.
  - If DmemAck is also high this cycle: zero-wait completion, no stall, stay IDLE.
  - If DmemAck is low: StallM=1, go to WAIT.
  - If not MemOp: DmemReq=0, StallM=0.
- FSM state WAIT:
  - DmemReq=1 with the held addr/data/we, stable until ack.
  - StallM = ~DmemAck.
  - On DmemAck: return to IDLE.
  - M-stage inputs are ignored in WAIT; upstream is frozen anyway.
- Handshake rule: requester never withdraws or changes a request before ack. Ack while DmemReq=0 is ignored.
- Writeback register update at each rising edge:
  - Completion cycle (IDLE with no MemOp, or an acked access): ALUOutW, WriteRegW, MemtoRegW and RegWriteW take the M (or held) values, gated by ValidM. ReadDataW takes DmemRData on a load and holds otherwise.
  - Stall cycle: bubble. RegWriteW=0, MemtoRegW=0, others hold.
- Latency: non-memory instruction reaches W one cycle after M. A load with ack after N wait cycles reaches W N+1 cycles after first presentation.
- Stores never assert RegWriteW, even if RegWriteM is set.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined, the block adds output MisalignW (1 bit, reset 0). A MemOp with ALUOutM[1:0]!=0 issues no DmemReq and no stall. The W update is a bubble (RegWriteW=0), and MisalignW pulses 1 for one cycle.
- When undefined, the port is absent and the address is passed through unmodified. Alignment is then the memory's responsibility.

Decomposition:
- Shared package (mips_pkg): DATA_W and REG_W constants, and the FSM state enum {IDLE, WAIT}.
- One natural sub-module, mem_wb_reg: the W-stage pipeline register with bubble/hold control. The handshake FSM stays in the top.

Test Plan:
- ALU op with ValidM=1, RegWriteM=1, ALUOutM=0x0000_002A, WriteRegM=5: next cycle ALUOutW=0x2A, WriteRegW=5, RegWriteW=1, ResultW=0x2A, no DmemReq.
- Load at 0x100 with DmemAck on the first cycle and DmemRData=0xDEAD_BEEF: StallM never rises; next cycle ReadDataW=0xDEADBEEF, MemtoRegW=1, ResultW=0xDEADBEEF.
- Store at 0x104 with data 0x1234 and ack after 3 wait cycles: StallM=1 for exactly 3 cycles. DmemAddr and DmemWData stay stable for 4 cycles; RegWriteW=0 throughout.
- Load with ack after 2 cycles, while ALUOutM is changed to garbage during the wait: DmemAddr stays at the original value. W shows bubbles for 2 cycles, then the correct load.
- rst_n pulsed low in WAIT: DmemReq=0 and all W outputs 0 immediately. An ack arriving after reset release causes no W update.
- Misaligned address 0x102 with MEM_MISALIGN_TRAP_EN defined: no DmemReq, MisalignW=1 for one cycle, RegWriteW=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and FSM state type for the MIPS memory/writeback stages.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// M/W pipeline register: loads the writeback bundle on a completion cycle,
// otherwise inserts a bubble (write-enable and load flag low, data held).
module mem_wb_reg #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              load_en,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] read_data,
    input  logic [REG_W-1:0]  write_reg,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    output logic [DATA_W-1:0] alu_out_w,
    output logic [DATA_W-1:0] read_data_w,
    output logic [REG_W-1:0]  write_reg_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w
);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_w    <= '0;
            read_data_w  <= '0;
            write_reg_w  <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end else if (advance) begin
            alu_out_w    <= alu_out;
            write_reg_w  <= write_reg;
            reg_write_w  <= reg_write;
            mem_to_reg_w <= mem_to_reg;
            if (load_en) begin
                read_data_w <= read_data;
            end
        end else begin
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: req/ack data-memory handshake, StallM generation and W register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ValidM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    output logic              DmemReq,
    output logic              DmemWe,
    output logic [DATA_W-1:0] DmemAddr,
    output logic [DATA_W-1:0] DmemWData,
    input  logic              DmemAck,
    input  logic [DATA_W-1:0] DmemRData,
    output logic              StallM,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              MisalignW,
`endif
    output logic [DATA_W-1:0] ResultW
);
    import mips_pkg::*;

    mem_state_t        state, state_next;

    logic [DATA_W-1:0] held_addr, held_wdata;
    logic [REG_W-1:0]  held_wreg;
    logic              held_we, held_rw, held_load;

    logic              mem_op_raw, misalign, mem_op, req;
    logic              advance, load_en;
    logic [DATA_W-1:0] wb_alu;
    logic [REG_W-1:0]  wb_wreg;
    logic              wb_rw, wb_mtr;

    // A slot with both load and store flags set behaves as a store.
    assign mem_op_raw = ValidM & (MemtoRegM | MemWriteM);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op_raw & (ALUOutM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = mem_op_raw & ~misalign;

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        DmemWe     = 1'b0;
        DmemAddr   = ALUOutM;
        DmemWData  = WriteDataM;
        StallM     = 1'b0;
        advance    = 1'b0;
        load_en    = 1'b0;
        wb_alu     = ALUOutM;
        wb_wreg    = WriteRegM;
        wb_rw      = ValidM & RegWriteM & ~MemWriteM;
        wb_mtr     = ValidM & MemtoRegM & ~MemWriteM;

        case (state)
            IDLE: begin
                DmemWe  = mem_op & MemWriteM;
                load_en = mem_op & MemtoRegM & ~MemWriteM;
                if (mem_op) begin
                    req = 1'b1;
                    if (DmemAck) begin
                        advance = 1'b1;
                    end else begin
                        StallM     = 1'b1;
                        state_next = WAIT;
                    end
                end else begin
                    advance = ~misalign;
                end
            end
            WAIT: begin
                // Request is replayed from the holding registers; M inputs are ignored.
                req       = 1'b1;
                DmemWe    = held_we;
                DmemAddr  = held_addr;
                DmemWData = held_wdata;
                wb_alu    = held_addr;
                wb_wreg   = held_wreg;
                wb_rw     = held_rw;
                wb_mtr    = held_load;
                load_en   = held_load;
                StallM    = ~DmemAck;
                if (DmemAck) begin
                    advance    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the request is gated by rst_n so it drops the instant reset asserts.
    assign DmemReq = req & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_addr  <= '0;
            held_wdata <= '0;
            held_wreg  <= '0;
            held_we    <= 1'b0;
            held_rw    <= 1'b0;
            held_load  <= 1'b0;
        end else if (state == IDLE && mem_op) begin
            held_addr  <= ALUOutM;
            held_wdata <= WriteDataM;
            held_wreg  <= WriteRegM;
            held_we    <= MemWriteM;
            held_rw    <= RegWriteM & ~MemWriteM;
            held_load  <= MemtoRegM & ~MemWriteM;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MisalignW <= 1'b0;
        end else begin
            MisalignW <= (state == IDLE) & misalign;
        end
    end
`endif

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance      (advance),
        .load_en      (load_en),
        .alu_out      (wb_alu),
        .read_data    (DmemRData),
        .write_reg    (wb_wreg),
        .reg_write    (wb_rw),
        .mem_to_reg   (wb_mtr),
        .alu_out_w    (ALUOutW),
        .read_data_w  (ReadDataW),
        .write_reg_w  (WriteRegW),
        .reg_write_w  (RegWriteW),
        .mem_to_reg_w (MemtoRegW)
    );

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction
// stream checked against a transaction-level model of the memory stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidM, RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        DmemReq, DmemWe, DmemAck, StallM;
    logic [31:0] DmemAddr, DmemWData, DmemRData;
    logic [31:0] ALUOutW, ReadDataW, ResultW;
    logic [4:0]  WriteRegW;
    logic        RegWriteW, MemtoRegW;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ValidM     (ValidM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .WriteRegM  (WriteRegM),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .DmemReq    (DmemReq),
        .DmemWe     (DmemWe),
        .DmemAddr   (DmemAddr),
        .DmemWData  (DmemWData),
        .DmemAck    (DmemAck),
        .DmemRData  (DmemRData),
        .StallM     (StallM),
        .ALUOutW    (ALUOutW),
        .ReadDataW  (ReadDataW),
        .WriteRegW  (WriteRegW),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
`ifdef MEM_MISALIGN_TRAP_EN
        .MisalignW  (MisalignW),
`endif
        .ResultW    (ResultW)
    );

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        rw;
        logic        mtr;
        logic        mw;
        logic [31:0] rdata;
    } instr_t;

    int checks = 0;
    int passed = 0;

    // Expected architectural W-stage contents.
    logic [31:0] exp_alu, exp_rd;
    logic [4:0]  exp_wreg;
    logic        exp_rw, exp_mtr, exp_mis, exp_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic instr_t mk(input logic v, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [4:0] wr, input logic rw, input logic mtr,
                                  input logic mw, input logic [31:0] rd);
        instr_t r;
        r.valid = v;  r.alu = a;   r.wdata = wd; r.wreg = wr;
        r.rw    = rw; r.mtr = mtr; r.mw    = mw; r.rdata = rd;
        return r;
    endfunction

    function automatic instr_t rand_instr(input logic aligned);
        instr_t r;
        int kind;
        kind    = $urandom_range(0, 3);
        r.valid = ($urandom_range(0, 7) != 0);
        r.alu   = aligned ? ($urandom & 32'hFFFF_FFFC) : $urandom;
        r.wdata = $urandom;
        r.wreg  = 5'($urandom_range(0, 31));
        r.rw    = 1'($urandom_range(0, 1));
        r.mtr   = (kind == 1) || (kind == 3);
        r.mw    = (kind == 2) || (kind == 3);
        r.rdata = $urandom;
        return r;
    endfunction

    task automatic apply(input instr_t i, input logic ack, input logic [31:0] rd);
        @(negedge clk);
        ValidM     = i.valid;
        ALUOutM    = i.alu;
        WriteDataM = i.wdata;
        WriteRegM  = i.wreg;
        RegWriteM  = i.rw;
        MemtoRegM  = i.mtr;
        MemWriteM  = i.mw;
        DmemAck    = ack;
        DmemRData  = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_w();
        check("RegWriteW", {31'd0, RegWriteW}, {31'd0, exp_rw});
        check("MemtoRegW", {31'd0, MemtoRegW}, {31'd0, exp_mtr});
        check("ReadDataW", ReadDataW, exp_rd);
        if (exp_known) begin
            check("ALUOutW", ALUOutW, exp_alu);
            check("WriteRegW", {27'd0, WriteRegW}, {27'd0, exp_wreg});
            check("ResultW", ResultW, exp_mtr ? exp_rd : exp_alu);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        check("MisalignW", {31'd0, MisalignW}, {31'd0, exp_mis});
`endif
    endtask

    // One instruction through M; a memory op is acked after lat wait cycles.
    task automatic run_instr(input instr_t i, input int lat);
        logic memop, mis, is_load;
        instr_t g;
        memop   = i.valid & (i.mtr | i.mw);
        is_load = i.mtr & ~i.mw;
        mis     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = memop && (i.alu[1:0] != 2'b00);
`endif
        if (!memop || mis) begin
            apply(i, 1'($urandom_range(0, 1)), $urandom);
            check("DmemReq_idle", {31'd0, DmemReq}, 32'd0);
            check("StallM_idle", {31'd0, StallM}, 32'd0);
            tick();
            exp_mis = mis;
            exp_mtr = 1'b0;
            if (mis) begin
                exp_rw = 1'b0;
            end else begin
                exp_rw = i.valid & i.rw;
                if (i.valid) begin
                    exp_alu   = i.alu;
                    exp_wreg  = i.wreg;
                    exp_known = 1'b1;
                end else begin
                    exp_known = 1'b0;
                end
            end
            check_w();
        end else begin
            for (int k = 0; k <= lat; k++) begin
                g = (k == 0) ? i : rand_instr(1'b0);
                apply(g, k == lat, (k == lat) ? i.rdata : $urandom);
                check("DmemReq_busy", {31'd0, DmemReq}, 32'd1);
                check("DmemWe", {31'd0, DmemWe}, {31'd0, i.mw});
                check("DmemAddr", DmemAddr, i.alu);
                if (i.mw) check("DmemWData", DmemWData, i.wdata);
                check("StallM_busy", {31'd0, StallM}, {31'd0, k < lat});
                tick();
                exp_mis = 1'b0;
                if (k < lat) begin
                    exp_rw  = 1'b0;
                    exp_mtr = 1'b0;
                end else begin
                    exp_alu   = i.alu;
                    exp_wreg  = i.wreg;
                    exp_known = 1'b1;
                    exp_rw    = i.rw & ~i.mw;
                    exp_mtr   = is_load;
                    if (is_load) exp_rd = i.rdata;
                end
                check_w();
            end
        end
    endtask

    task automatic model_reset();
        exp_alu = '0; exp_rd = '0; exp_wreg = '0;
        exp_rw = 1'b0; exp_mtr = 1'b0; exp_mis = 1'b0; exp_known = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ValidM = 0; ALUOutM = 0; WriteDataM = 0; WriteRegM = 0;
        RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; DmemAck = 0; DmemRData = 0;
        model_reset();
        #12;
        check("reset_DmemReq", {31'd0, DmemReq}, 32'd0);
        check_w();
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op
        run_instr(mk(1, 32'h0000_002A, 32'h0, 5'd5, 1, 0, 0, 32'h0), 0);
        // Zero-wait load
        run_instr(mk(1, 32'h0000_0100, 32'h0, 5'd7, 1, 1, 0, 32'hDEAD_BEEF), 0);
        // Store with RegWriteM set, 3 wait cycles
        run_instr(mk(1, 32'h0000_0104, 32'h0000_1234, 5'd9, 1, 0, 1, 32'h0), 3);
        // Load with 2 wait cycles, garbage on M inputs while waiting
        run_instr(mk(1, 32'h0000_0200, 32'h0, 5'd3, 1, 1, 0, 32'hCAFE_F00D), 2);
        // Load+store together is a store
        run_instr(mk(1, 32'h0000_0300, 32'h5555_AAAA, 5'd4, 1, 1, 1, 32'h1111_1111), 1);

        // Reset while waiting: request and W drop at once, a late ack is ignored.
        apply(mk(1, 32'h0000_0400, 32'h0, 5'd6, 1, 1, 0, 32'h0), 1'b0, 32'h0);
        check("rst_pre_stall", {31'd0, StallM}, 32'd1);
        tick();
        exp_rw = 1'b0; exp_mtr = 1'b0;
        check_w();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_DmemReq", {31'd0, DmemReq}, 32'd0);
        check_w();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        ValidM = 0; ALUOutM = 0; WriteRegM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        DmemAck = 1'b1; DmemRData = 32'hBAD0_BAD0;
        #1;
        check("late_ack_DmemReq", {31'd0, DmemReq}, 32'd0);
        check("late_ack_StallM", {31'd0, StallM}, 32'd0);
        tick();
        check_w();

`ifdef MEM_MISALIGN_TRAP_EN
        run_instr(mk(1, 32'h0000_0102, 32'h0, 5'd8, 1, 1, 0, 32'h0), 0);
        run_instr(mk(1, 32'h0000_0010, 32'h0, 5'd2, 1, 0, 0, 32'h0), 0);
`endif

        for (int n = 0; n < 80; n++) begin
            run_instr(rand_instr(1'b1), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
